// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO, clocked entirely by rclk.
// Tracks the read pointer, flags empty, and streams RAM words through a skid buffer.
module fifo_rd_ctrl #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic             rden,
    input  logic [DSIZE-1:0] rdata,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             rempty,
    output logic [ASIZE:0]   rlevel
);

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        for (int i = 0; i <= ASIZE; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [ASIZE:0]   rbin_q;
    logic [ASIZE:0]   rptr_q;
    logic             rempty_q;
    logic [ASIZE:0]   rlevel_q;
    logic             inflight_q;
    logic [1:0]       bufcnt_q, bufcnt_d;
    logic [DSIZE-1:0] buf0_q, buf0_d;
    logic [DSIZE-1:0] buf1_q, buf1_d;

    logic [1:0]     used;
    logic           has_credit;
    logic           pop;
    logic           pop_buf;
    logic           push_buf;
    logic [ASIZE:0] rbinnext;
    logic [ASIZE:0] rgraynext;
    logic [ASIZE:0] wbin;

    assign used       = bufcnt_q + {1'b0, inflight_q};
    assign has_credit = used < 2'd2;

    // The word arriving from RAM is visible straight away when the buffer is empty
    assign m_valid = (bufcnt_q != 2'd0) | inflight_q;
    assign m_data  = (bufcnt_q != 2'd0) ? buf0_q : rdata;
    assign pop     = m_valid & m_ready;

    assign rden      = ~rempty_q & (has_credit | pop);
    assign rbinnext  = rbin_q + {{ASIZE{1'b0}}, rden};
    assign rgraynext = (rbinnext >> 1) ^ rbinnext;
    assign wbin      = gray2bin(rq2_wptr);

    assign pop_buf  = pop & (bufcnt_q != 2'd0);
    assign push_buf = inflight_q & ~(pop & (bufcnt_q == 2'd0));

    always_comb begin
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        bufcnt_d = bufcnt_q;
        if (pop_buf) begin
            buf0_d   = buf1_q;
            bufcnt_d = bufcnt_q - 2'd1;
        end
        if (push_buf) begin
            if (bufcnt_d == 2'd0) begin
                buf0_d = rdata;
            end else begin
                buf1_d = rdata;
            end
            bufcnt_d = bufcnt_d + 2'd1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q     <= '0;
            rptr_q     <= '0;
            rempty_q   <= 1'b1;
            rlevel_q   <= '0;
            inflight_q <= 1'b0;
            bufcnt_q   <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            rbin_q     <= rbinnext;
            rptr_q     <= rgraynext;
            rempty_q   <= (rgraynext == rq2_wptr);
            rlevel_q   <= wbin - rbinnext;
            inflight_q <= rden;
            bufcnt_q   <= bufcnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

    assign rptr   = rptr_q;
    assign raddr  = rbin_q[ASIZE-1:0];
    assign rempty = rempty_q;
    assign rlevel = rlevel_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a 1-cycle-latency RAM model.
// Vector table for the short sequences, hand-written loops for streaming cases.
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst;
    logic [4:0] rq2_wptr;
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic       rden;
    logic [7:0] rdata;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       rempty;
    logic [4:0] rlevel;

    fifo_rd_ctrl #(.ASIZE(4), .DSIZE(8)) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rq2_wptr(rq2_wptr),
        .rptr    (rptr),
        .raddr   (raddr),
        .rden    (rden),
        .rdata   (rdata),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .rempty  (rempty),
        .rlevel  (rlevel)
    );

    always #5 rclk = ~rclk;

    logic [7:0] mem [16];

    always @(posedge rclk) begin
        if (rden) rdata <= mem[raddr];
    end

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] g(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] dat(input int k);
        return 8'(k * 37 + 5);
    endfunction

    task automatic do_reset();
        rrst     = 1'b1;
        rq2_wptr = '0;
        m_ready  = 1'b0;
        @(posedge rclk);
        #1;
        rrst = 1'b0;
    endtask

    typedef struct {
        logic [4:0] wptr;
        logic       rdy;
        logic       rden;
        logic [3:0] raddr;
        logic       mv;
        logic [7:0] md;
        logic       re;
        logic [4:0] rptr;
        logic [4:0] lvl;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int beats, gaps, nrd, wcnt, popped, maxlvl, badstep, leak;
        logic [4:0] prevp;
        logic found;

        for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);

        tbl[0]  = '{5'b00000, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 5'b00000, 5'd0};
        tbl[1]  = '{5'b00001, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 1'b1, 5'b00000, 5'd0};
        tbl[2]  = '{5'b00001, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00, 1'b0, 5'b00000, 5'd1};
        tbl[3]  = '{5'b00001, 1'b1, 1'b0, 4'd1, 1'b1, 8'hA0, 1'b1, 5'b00001, 5'd0};
        tbl[4]  = '{5'b00001, 1'b1, 1'b0, 4'd1, 1'b0, 8'h00, 1'b1, 5'b00001, 5'd0};
        tbl[5]  = '{5'b00010, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00, 1'b1, 5'b00001, 5'd0};
        tbl[6]  = '{5'b00010, 1'b0, 1'b1, 4'd1, 1'b0, 8'h00, 1'b0, 5'b00001, 5'd2};
        tbl[7]  = '{5'b00010, 1'b0, 1'b1, 4'd2, 1'b1, 8'hA1, 1'b0, 5'b00011, 5'd1};
        tbl[8]  = '{5'b00010, 1'b0, 1'b0, 4'd3, 1'b1, 8'hA1, 1'b1, 5'b00010, 5'd0};
        tbl[9]  = '{5'b00010, 1'b1, 1'b0, 4'd3, 1'b1, 8'hA1, 1'b1, 5'b00010, 5'd0};
        tbl[10] = '{5'b00010, 1'b1, 1'b0, 4'd3, 1'b1, 8'hA2, 1'b1, 5'b00010, 5'd0};
        tbl[11] = '{5'b00010, 1'b1, 1'b0, 4'd3, 1'b0, 8'h00, 1'b1, 5'b00010, 5'd0};

        // Reset, single word, then a two-word burst under backpressure
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rq2_wptr = tbl[i].wptr;
            m_ready  = tbl[i].rdy;
            @(negedge rclk);
            chk($sformatf("v%0d_rden", i), 32'(rden), 32'(tbl[i].rden));
            chk($sformatf("v%0d_raddr", i), 32'(raddr), 32'(tbl[i].raddr));
            chk($sformatf("v%0d_mvalid", i), 32'(m_valid), 32'(tbl[i].mv));
            if (tbl[i].mv)
                chk($sformatf("v%0d_mdata", i), 32'(m_data), 32'(tbl[i].md));
            chk($sformatf("v%0d_rempty", i), 32'(rempty), 32'(tbl[i].re));
            chk($sformatf("v%0d_rptr", i), 32'(rptr), 32'(tbl[i].rptr));
            chk($sformatf("v%0d_rlevel", i), 32'(rlevel), 32'(tbl[i].lvl));
            @(posedge rclk);
            #1;
        end

        // Full 16-word stream with ready held high
        do_reset();
        rq2_wptr = g(16);
        m_ready  = 1'b1;
        beats = 0;
        gaps  = 0;
        for (int c = 0; c < 60 && beats < 16; c++) begin
            @(negedge rclk);
            if (m_valid) begin
                chk("stream_data", 32'(m_data), 32'(8'(8'hA0 + beats)));
                beats++;
            end else if (beats > 0) begin
                gaps++;
            end
            @(posedge rclk);
            #1;
        end
        chk("stream_beats", 32'(beats), 32'd16);
        chk("stream_gaps", 32'(gaps), 32'd0);
        @(negedge rclk);
        chk("stream_rptr", 32'(rptr), 32'b11000);
        chk("stream_rempty", 32'(rempty), 32'd1);
        chk("stream_idle", 32'(m_valid), 32'd0);

        // Ten words waiting, consumer stalled
        do_reset();
        rq2_wptr = g(10);
        nrd = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge rclk);
            if (rden) nrd++;
            @(posedge rclk);
            #1;
        end
        @(negedge rclk);
        chk("bp_rden_pulses", 32'(nrd), 32'd2);
        chk("bp_mvalid", 32'(m_valid), 32'd1);
        chk("bp_mdata", 32'(m_data), 32'hA0);
        chk("bp_rlevel", 32'(rlevel), 32'd8);
        m_ready = 1'b1;
        beats = 0;
        gaps  = 0;
        for (int c = 0; c < 40 && beats < 10; c++) begin
            if (m_valid) begin
                chk("bp_data", 32'(m_data), 32'(8'(8'hA0 + beats)));
                beats++;
            end else begin
                gaps++;
            end
            @(negedge rclk);
        end
        chk("bp_beats", 32'(beats), 32'd10);
        chk("bp_gaps", 32'(gaps), 32'd0);

        // Bursty writer, random ready, 40 words across pointer wrap
        do_reset();
        @(negedge rclk);
        prevp   = rptr;
        @(posedge rclk);
        #1;
        wcnt    = 0;
        popped  = 0;
        maxlvl  = 0;
        badstep = 0;
        for (int c = 0; c < 2000 && popped < 40; c++) begin
            if (wcnt < 40 && (wcnt - popped) < 16 && ((c / 6) % 3) != 2
                && $urandom_range(0, 3) != 0) begin
                mem[wcnt % 16] = dat(wcnt);
                wcnt++;
                rq2_wptr = g(wcnt);
            end
            m_ready = 1'($urandom_range(0, 1));
            @(negedge rclk);
            if (m_valid && m_ready) begin
                chk("wrap_data", 32'(m_data), 32'(dat(popped)));
                popped++;
            end
            if (int'(rlevel) > maxlvl) maxlvl = int'(rlevel);
            if ($countones(rptr ^ prevp) > 1) badstep++;
            prevp = rptr;
            @(posedge rclk);
            #1;
        end
        chk("wrap_count", 32'(popped), 32'd40);
        chk("wrap_lvl_bound", 32'(maxlvl <= 16), 32'd1);
        chk("wrap_gray_steps", 32'(badstep), 32'd0);
        @(negedge rclk);
        chk("wrap_rptr", 32'(rptr), 32'(g(40)));

        // Reset while a word is being presented and another is in flight
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
        do_reset();
        rq2_wptr = g(5);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge rclk);
            if (m_valid) found = 1'b1;
            else begin
                @(posedge rclk);
                #1;
            end
        end
        chk("mid_found_valid", 32'(found), 32'd1);
        chk("mid_rden_busy", 32'(rden), 32'd1);
        rrst     = 1'b1;
        rq2_wptr = '0;
        @(posedge rclk);
        #1;
        rrst    = 1'b0;
        m_ready = 1'b1;
        @(negedge rclk);
        chk("mid_rptr", 32'(rptr), 32'd0);
        chk("mid_raddr", 32'(raddr), 32'd0);
        chk("mid_rempty", 32'(rempty), 32'd1);
        chk("mid_rlevel", 32'(rlevel), 32'd0);
        chk("mid_mvalid", 32'(m_valid), 32'd0);
        chk("mid_rden", 32'(rden), 32'd0);
        leak = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge rclk);
            if (m_valid) leak++;
        end
        chk("mid_no_stale", 32'(leak), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
